// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states and byte strobes.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } lsu_state_t;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H_LO = 4'b0011;
   localparam logic [3:0] STRB_H_HI = 4'b1100;
   localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/load_store_unit_data_align.sv
// Combinational request legality check, store lane formatting and load lane extraction.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rdata,
   output logic        req_ok,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata,
   output logic [31:0] ld_data
);

   logic legal;
   logic aligned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      legal   = 1'b0;
      aligned = 1'b1;
      case (req_funct3)
         F3_B:  legal = 1'b1;
         F3_H:  begin legal = 1'b1;    aligned = ~req_addr_lo[0]; end
         F3_W:  begin legal = 1'b1;    aligned = (req_addr_lo == 2'b00); end
         F3_BU: legal = ~req_we;
         F3_HU: begin legal = ~req_we; aligned = ~req_addr_lo[0]; end
         default: legal = 1'b0;
      endcase
      req_ok = legal & aligned;
   end

   // Reads drive no strobes and no data so the bus sees a clean read.
   always_comb begin
      st_wstrb = STRB_NONE;
      st_wdata = 32'h0;
      if (req_we) begin
         case (req_funct3)
            F3_B: begin
               st_wstrb = STRB_B << req_addr_lo;
               st_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
               st_wstrb = req_addr_lo[1] ? STRB_H_HI : STRB_H_LO;
               st_wdata = {2{req_wdata[15:0]}};
            end
            F3_W: begin
               st_wstrb = STRB_W;
               st_wdata = req_wdata;
            end
            default: begin
               st_wstrb = STRB_NONE;
               st_wdata = 32'h0;
            end
         endcase
      end
   end

   always_comb begin
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_rdata[7:0];
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         default: ld_byte = ld_rdata[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_HU:   ld_data = {16'h0, ld_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory request into a handshaked word-bus access
// with bus-wait timeout, and returns formatted load data with a done/err pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for core_req
//   ACCESS | mem_valid high, waiting for mem_ready or timeout
//   DONE   | core_done pulse, core_err=0
//   ERR    | core_done pulse, core_err=1 (illegal, misaligned, timeout)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [2:0]        core_funct3,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_busy,
   output logic              core_done,
   output logic              core_err,
   output logic [31:0]       core_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t        state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [2:0]        funct3_q,     funct3_d;
   logic [1:0]        addr_lo_q,    addr_lo_d;
   logic              core_busy_q,  core_busy_d;
   logic              core_done_q,  core_done_d;
   logic              core_err_q,   core_err_d;
   logic [31:0]       core_rdata_q, core_rdata_d;
   logic              mem_valid_q,  mem_valid_d;
   logic              mem_we_q,     mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [3:0]        mem_wstrb_q,  mem_wstrb_d;
   logic [31:0]       mem_wdata_q,  mem_wdata_d;

   logic        req_ok;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   lsu_data_align u_align (
      .req_we      (core_we),
      .req_funct3  (core_funct3),
      .req_addr_lo (core_addr[1:0]),
      .req_wdata   (core_wdata),
      .ld_funct3   (funct3_q),
      .ld_addr_lo  (addr_lo_q),
      .ld_rdata    (mem_rdata),
      .req_ok      (req_ok),
      .st_wstrb    (st_wstrb),
      .st_wdata    (st_wdata),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      funct3_d     = funct3_q;
      addr_lo_d    = addr_lo_q;
      core_busy_d  = core_busy_q;
      core_done_d  = 1'b0;
      core_err_d   = 1'b0;
      core_rdata_d = core_rdata_q;
      mem_valid_d  = mem_valid_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (core_req) begin
               core_busy_d = 1'b1;
               funct3_d    = core_funct3;
               addr_lo_d   = core_addr[1:0];
               if (!req_ok) begin
                  state_d     = ST_ERR;
                  core_done_d = 1'b1;
                  core_err_d  = 1'b1;
               end else begin
                  state_d     = ST_ACCESS;
                  cnt_d       = '0;
                  mem_valid_d = 1'b1;
                  mem_we_d    = core_we;
                  mem_addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
                  mem_wstrb_d = st_wstrb;
                  mem_wdata_d = st_wdata;
               end
            end
         end
         ST_ACCESS: begin
            // Ready takes priority over a timeout expiring in the same cycle.
            if (mem_ready) begin
               state_d     = ST_DONE;
               mem_valid_d = 1'b0;
               core_done_d = 1'b1;
               if (!mem_we_q) core_rdata_d = ld_data;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_ERR;
               mem_valid_d = 1'b0;
               core_done_d = 1'b1;
               core_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE, ST_ERR: begin
            state_d     = ST_IDLE;
            core_busy_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         core_busy_q  <= 1'b0;
         core_done_q  <= 1'b0;
         core_err_q   <= 1'b0;
         core_rdata_q <= 32'h0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wstrb_q  <= STRB_NONE;
         mem_wdata_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         funct3_q     <= funct3_d;
         addr_lo_q    <= addr_lo_d;
         core_busy_q  <= core_busy_d;
         core_done_q  <= core_done_d;
         core_err_q   <= core_err_d;
         core_rdata_q <= core_rdata_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign core_busy  = core_busy_q;
   assign core_done  = core_done_q;
   assign core_err   = core_err_q;
   assign core_rdata = core_rdata_q;
   assign mem_valid  = mem_valid_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
